// File: rtl/st_channel_skid_adapter_if.sv
// Avalon-ST channel bus: one beat of payload, channel and framing with valid/ready.
// The master drives the beat; the slave drives ready.
interface st_channel_skid_adapter_if #(
    parameter int DATA_W = 8,
    parameter int CH_W   = 1
);
    logic              ready;
    logic              valid;
    logic [DATA_W-1:0] data;
    logic [CH_W-1:0]   channel;
    logic              startofpacket;
    logic              endofpacket;

    modport master (
        input  ready,
        output valid, data, channel, startofpacket, endofpacket
    );

    modport slave (
        output ready,
        input  valid, data, channel, startofpacket, endofpacket
    );
endinterface

// File: rtl/st_channel_skid_adapter.sv
// Avalon-ST channel adapter: remaps and latches the packet channel, drops out-of-range
// packets, flags framing errors, and registers every output through a two-entry skid.
//
//   state | meaning
//   IDLE  | between packets, waiting for an SOP beat
//   PASS  | inside a forwarded packet, channel held in ch_q
//   DROP  | inside an out-of-range packet, beats discarded
module st_channel_skid_adapter #(
    parameter int          DATA_W    = 8,
    parameter int          IN_CH_W   = 1,
    parameter int          OUT_CH_W  = 8,
    parameter int unsigned MAX_CH    = 1,
    parameter int unsigned CH_OFFSET = 0,
    parameter int          CNT_W     = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    st_channel_skid_adapter_if.slave  in_st,
    st_channel_skid_adapter_if.master out_st,
    output logic [CNT_W-1:0]          drop_count,
    output logic                      proto_err
);
    typedef enum logic [1:0] {IDLE, PASS, DROP} state_t;

    state_t              state_q, state_d;
    logic [OUT_CH_W-1:0] ch_q, ch_new, beat_ch;
    logic                accept, ch_in_range;
    logic                fwd, drop_pkt, frame_err;

    logic                in_ready_q;
    logic                out_valid_q, out_sop_q, out_eop_q;
    logic [DATA_W-1:0]   out_data_q;
    logic [OUT_CH_W-1:0] out_ch_q;
    logic                skid_valid_q, skid_sop_q, skid_eop_q;
    logic [DATA_W-1:0]   skid_data_q;
    logic [OUT_CH_W-1:0] skid_ch_q;
    logic                out_free, out_drain, skid_valid_d;

    assign accept      = in_st.valid & in_ready_q;
    assign ch_in_range = 32'(in_st.channel) <= MAX_CH;
    assign ch_new      = OUT_CH_W'(in_st.channel) + OUT_CH_W'(CH_OFFSET);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            ch_q       <= '0;
            drop_count <= '0;
            proto_err  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && fwd)
                ch_q <= ch_new;
            if (drop_pkt && drop_count != '1)
                drop_count <= drop_count + CNT_W'(1);
            if (frame_err)
                proto_err <= 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        fwd       = 1'b0;
        drop_pkt  = 1'b0;
        frame_err = 1'b0;
        beat_ch   = ch_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!in_st.startofpacket) begin
                        frame_err = 1'b1;
                    end else if (ch_in_range) begin
                        fwd     = 1'b1;
                        beat_ch = ch_new;
                        state_d = in_st.endofpacket ? IDLE : PASS;
                    end else begin
                        drop_pkt = 1'b1;
                        state_d  = in_st.endofpacket ? IDLE : DROP;
                    end
                end
            end
            PASS: begin
                if (accept) begin
                    fwd       = 1'b1;
                    frame_err = in_st.startofpacket;
                    if (in_st.endofpacket)
                        state_d = IDLE;
                end
            end
            DROP: begin
                if (accept && in_st.endofpacket)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // A forwarded beat only arrives while the skid is empty, because in_ready mirrors it.
    assign out_free     = ~out_valid_q | out_st.ready;
    assign out_drain    = out_valid_q & out_st.ready;
    assign skid_valid_d = skid_valid_q ? ~out_drain : (fwd & ~out_free);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_ready_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_ch_q     <= '0;
            out_sop_q    <= 1'b0;
            out_eop_q    <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_ch_q    <= '0;
            skid_sop_q   <= 1'b0;
            skid_eop_q   <= 1'b0;
        end else begin
            in_ready_q   <= ~skid_valid_d;
            skid_valid_q <= skid_valid_d;
            if (fwd && !out_free) begin
                skid_data_q <= in_st.data;
                skid_ch_q   <= beat_ch;
                skid_sop_q  <= in_st.startofpacket;
                skid_eop_q  <= in_st.endofpacket;
            end
            if (fwd && out_free) begin
                out_valid_q <= 1'b1;
                out_data_q  <= in_st.data;
                out_ch_q    <= beat_ch;
                out_sop_q   <= in_st.startofpacket;
                out_eop_q   <= in_st.endofpacket;
            end else if (out_drain) begin
                out_valid_q <= skid_valid_q;
                if (skid_valid_q) begin
                    out_data_q <= skid_data_q;
                    out_ch_q   <= skid_ch_q;
                    out_sop_q  <= skid_sop_q;
                    out_eop_q  <= skid_eop_q;
                end
            end
        end
    end

    assign in_st.ready          = in_ready_q;
    assign out_st.valid         = out_valid_q;
    assign out_st.data          = out_data_q;
    assign out_st.channel       = out_ch_q;
    assign out_st.startofpacket = out_sop_q;
    assign out_st.endofpacket   = out_eop_q;
endmodule
